// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// redirect FSM states and the per-rule stall/flush vectors.
// Latency: n/a (constants only). Backpressure: n/a.
package hazard_pkg;

  // Bit positions in the stall/flush vectors
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;

  localparam logic [4:0] M_PC    = 5'(1 << STG_PC);
  localparam logic [4:0] M_IFID  = 5'(1 << STG_IFID);
  localparam logic [4:0] M_IDEX  = 5'(1 << STG_IDEX);
  localparam logic [4:0] M_EXMEM = 5'(1 << STG_EXMEM);
  localparam logic [4:0] M_MEMWB = 5'(1 << STG_MEMWB);

  // Data-bus wait freezes everything up to EX/MEM and bubbles MEM/WB
  localparam logic [4:0] STALL_DWAIT = M_PC | M_IFID | M_IDEX | M_EXMEM;
  localparam logic [4:0] FLUSH_DWAIT = M_MEMWB;
  // Watchdog trap squashes every younger-than-WB stage
  localparam logic [4:0] FLUSH_WDOG  = M_IFID | M_IDEX | M_EXMEM;
  // Taken jump squashes the two wrong-path instructions behind EX
  localparam logic [4:0] FLUSH_JUMP  = M_IFID | M_IDEX;
  // Load-use holds fetch/decode and injects a bubble into EX
  localparam logic [4:0] STALL_LU    = M_PC | M_IFID;
  localparam logic [4:0] FLUSH_LU    = M_IDEX;
  // Fetch wait holds the PC and bubbles decode
  localparam logic [4:0] STALL_IWAIT = M_PC;
  localparam logic [4:0] FLUSH_IWAIT = M_IFID;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_PEND = 2'd1,
    RD_FIRE = 2'd2
  } redir_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for hazard performance statistics.
// Latency: count visible one cycle after inc. Backpressure: none, sticks at all-ones.
// Ports: clk; clr (synchronous clear, wins over inc); inc (count one event); cnt (value).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: per-stage stall/flush, PC redirect, bus watchdog.
// Latency: stall/flush/redirect combinational; counters and timeout_o one cycle later.
// Backpressure: bus waits hold the pipe; a jump during an unfinished fetch is parked until it ends.
// Ports: clk/rst; jump_en_i/jump_addr_i from EX; ex_is_load_i/rs_hit_i for load-use;
//   ibus_*/dbus_* busy/done status; stall_o/flush_o indexed pc,if_id,id_ex,ex_mem,mem_wb;
//   jump_en_o/jump_addr_o redirect; timeout_o sticky trap flag; cnt_*_o event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter int              LU_BUBBLES = 1,
  parameter int              TO_CYCLES  = 1023,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(64'h8000_0000),
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [XLEN-1:0]  jump_addr_i,
  input  logic             ex_is_load_i,
  input  logic             rs_hit_i,
  input  logic             ibus_busy_i,
  input  logic             ibus_done_i,
  input  logic             dbus_busy_i,
  input  logic             dbus_done_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       flush_o,
  output logic             jump_en_o,
  output logic [XLEN-1:0]  jump_addr_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cnt_dstall_o,
  output logic [CNT_W-1:0] cnt_istall_o,
  output logic [CNT_W-1:0] cnt_lu_o,
  output logic [CNT_W-1:0] cnt_redir_o
);

  localparam int WD_W = $clog2(TO_CYCLES + 1);

  redir_state_t    state, state_n;
  logic [XLEN-1:0] pend_addr, pend_addr_n;
  logic [1:0]      lu_cnt, lu_cnt_n;
  logic [WD_W-1:0] wd_cnt, wd_cnt_n;
  logic            timeout_q, timeout_n;

  logic [4:0]      stall, flush;
  logic            jen;
  logic [XLEN-1:0] jaddr;
  logic            inc_dstall, inc_istall, inc_lu;

  logic iwait, dwait, wd_fire, jump_rule, lu_hit;

  assign iwait     = ibus_busy_i & ~ibus_done_i;
  assign dwait     = dbus_busy_i & ~dbus_done_i;
  assign wd_fire   = (wd_cnt == WD_W'(TO_CYCLES - 1)) & (iwait | dwait);
  // A parked redirect owns the PC, so new jumps are not accepted in PEND
  assign jump_rule = (state == RD_FIRE) | (jump_en_i & (state == RD_IDLE));
  assign lu_hit    = (lu_cnt != 2'd0) | (rs_hit_i & ex_is_load_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RD_IDLE;
      pend_addr <= '0;
      lu_cnt    <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      pend_addr <= pend_addr_n;
      lu_cnt    <= lu_cnt_n;
      wd_cnt    <= wd_cnt_n;
      timeout_q <= timeout_n;
    end
  end

  always_comb begin
    stall       = '0;
    flush       = '0;
    jen         = 1'b0;
    jaddr       = '0;
    state_n     = state;
    pend_addr_n = pend_addr;
    lu_cnt_n    = lu_cnt;
    timeout_n   = timeout_q;
    inc_dstall  = 1'b0;
    inc_istall  = 1'b0;
    inc_lu      = 1'b0;
    wd_cnt_n    = (iwait | dwait) ? wd_cnt + WD_W'(1) : '0;

    if (wd_fire) begin
      jen       = 1'b1;
      jaddr     = TRAP_VEC;
      flush     = FLUSH_WDOG;
      state_n   = RD_IDLE;
      lu_cnt_n  = '0;
      wd_cnt_n  = '0;
      timeout_n = 1'b1;
    end else if (dwait) begin
      // EX is frozen: any jump there re-presents later; a parked fetch may still finish
      stall      = STALL_DWAIT;
      flush      = FLUSH_DWAIT;
      inc_dstall = 1'b1;
      if ((state == RD_PEND) && ibus_done_i) state_n = RD_FIRE;
    end else if (jump_rule) begin
      flush    = FLUSH_JUMP;
      lu_cnt_n = '0;
      if ((state == RD_IDLE) && iwait) begin
        state_n       = RD_PEND;
        pend_addr_n   = jump_addr_i;
        stall[STG_PC] = 1'b1;
      end else begin
        jen     = 1'b1;
        jaddr   = (state == RD_FIRE) ? pend_addr : jump_addr_i;
        state_n = RD_IDLE;
      end
    end else begin
      if (lu_hit) begin
        stall    = STALL_LU;
        flush    = FLUSH_LU;
        inc_lu   = 1'b1;
        // lu_cnt holds the bubbles still owed after this one
        lu_cnt_n = (lu_cnt == 2'd0) ? 2'(LU_BUBBLES - 1) : lu_cnt - 2'd1;
      end else if (iwait) begin
        stall      = STALL_IWAIT;
        flush      = FLUSH_IWAIT;
        inc_istall = 1'b1;
      end
      if (state == RD_PEND) begin
        // Hold PC for the parked target and drop the wrong-path fetch
        stall[STG_PC]   = 1'b1;
        flush[STG_IFID] = 1'b1;
        inc_istall      = 1'b1;
        if (ibus_done_i) state_n = RD_FIRE;
      end
    end
  end

  assign stall_o     = rst ? 5'b0 : stall;
  assign flush_o     = rst ? 5'b0 : flush;
  assign jump_en_o   = rst ? 1'b0 : jen;
  assign jump_addr_o = rst ? '0 : jaddr;
  assign timeout_o   = timeout_q;

  sat_counter #(.W(CNT_W)) u_cnt_dstall (
    .clk(clk), .clr(rst), .inc(inc_dstall), .cnt(cnt_dstall_o));
  sat_counter #(.W(CNT_W)) u_cnt_istall (
    .clk(clk), .clr(rst), .inc(inc_istall), .cnt(cnt_istall_o));
  sat_counter #(.W(CNT_W)) u_cnt_lu (
    .clk(clk), .clr(rst), .inc(inc_lu), .cnt(cnt_lu_o));
  sat_counter #(.W(CNT_W)) u_cnt_redir (
    .clk(clk), .clr(rst), .inc(jen), .cnt(cnt_redir_o));

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int          XLEN  = 64;
  localparam int          LU_N  = 2;
  localparam int          TO_C  = 4;
  localparam int          CNT_W = 4;
  localparam logic [63:0] TRAP  = 64'h8000_0000;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             jump_en_i = 1'b0;
  logic [XLEN-1:0]  jump_addr_i = '0;
  logic             ex_is_load_i = 1'b0, rs_hit_i = 1'b0;
  logic             ibus_busy_i = 1'b0, ibus_done_i = 1'b0;
  logic             dbus_busy_i = 1'b0, dbus_done_i = 1'b0;
  logic [4:0]       stall_o, flush_o;
  logic             jump_en_o, timeout_o;
  logic [XLEN-1:0]  jump_addr_o;
  logic [CNT_W-1:0] cnt_dstall_o, cnt_istall_o, cnt_lu_o, cnt_redir_o;

  hazard_ctrl #(
    .XLEN(XLEN), .LU_BUBBLES(LU_N), .TO_CYCLES(TO_C), .TRAP_VEC(TRAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .ex_is_load_i(ex_is_load_i), .rs_hit_i(rs_hit_i),
    .ibus_busy_i(ibus_busy_i), .ibus_done_i(ibus_done_i),
    .dbus_busy_i(dbus_busy_i), .dbus_done_i(dbus_done_i),
    .stall_o(stall_o), .flush_o(flush_o),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .timeout_o(timeout_o),
    .cnt_dstall_o(cnt_dstall_o), .cnt_istall_o(cnt_istall_o),
    .cnt_lu_o(cnt_lu_o), .cnt_redir_o(cnt_redir_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a parked redirect, a one-shot "fire next" flag,
  // bubbles still owed, length of the current bus-wait run, event tallies.
  bit          m_pending, m_fire;
  logic [63:0] m_tgt;
  int          m_owed, m_run;
  bit          m_to;
  int          m_dst, m_ist, m_lu, m_red;

  // Last sampled DUT outputs for directed checks
  logic [4:0]  g_stall, g_flush;
  logic        g_jen;
  logic [63:0] g_jaddr;

  function automatic int bump(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic step(input bit r, input bit j, input logic [63:0] ja, input bit ld,
                      input bit hit, input bit ib, input bit id, input bit db, input bit dd);
    logic [4:0]  es, ef;
    bit          ej, iw, dw, waiting, ist;
    logic [63:0] ea;
    @(posedge clk);
    #1;
    rst = r; jump_en_i = j; jump_addr_i = ja; ex_is_load_i = ld; rs_hit_i = hit;
    ibus_busy_i = ib; ibus_done_i = id; dbus_busy_i = db; dbus_done_i = dd;
    #2;
    check_eq("timeout", timeout_o, m_to);
    check_eq("cnt_dstall", cnt_dstall_o, m_dst);
    check_eq("cnt_istall", cnt_istall_o, m_ist);
    check_eq("cnt_lu", cnt_lu_o, m_lu);
    check_eq("cnt_redir", cnt_redir_o, m_red);

    es = '0; ef = '0; ej = 0; ea = '0; ist = 0;
    iw = ib && !id;
    dw = db && !dd;
    waiting = iw || dw;
    if (r) begin
      m_pending = 0; m_fire = 0; m_tgt = '0; m_owed = 0; m_run = 0; m_to = 0;
      m_dst = 0; m_ist = 0; m_lu = 0; m_red = 0;
    end else begin
      if (m_run == TO_C - 1 && waiting) begin
        ej = 1; ea = TRAP; ef = 5'b01110;
        m_pending = 0; m_fire = 0; m_owed = 0; m_to = 1;
        m_run = 0;
      end else begin
        m_run = waiting ? m_run + 1 : 0;
        if (dw) begin
          es = 5'b01111; ef = 5'b10000; m_dst = bump(m_dst);
          if (m_pending && id) begin m_pending = 0; m_fire = 1; end
        end else if (m_fire || (j && !m_pending)) begin
          ef = 5'b00110; m_owed = 0;
          if (!m_fire && iw) begin
            m_pending = 1; m_tgt = ja; es = 5'b00001;
          end else begin
            ej = 1; ea = m_fire ? m_tgt : ja; m_fire = 0;
          end
        end else begin
          if (m_owed > 0 || (hit && ld)) begin
            if (m_owed == 0) m_owed = LU_N;
            m_owed--;
            es = 5'b00011; ef = 5'b00100; m_lu = bump(m_lu);
          end else if (iw) begin
            es = 5'b00001; ef = 5'b00010; ist = 1;
          end
          if (m_pending) begin
            es[0] = 1'b1; ef[1] = 1'b1; ist = 1;
            if (id) begin m_pending = 0; m_fire = 1; end
          end
          if (ist) m_ist = bump(m_ist);
        end
      end
      if (ej) m_red = bump(m_red);
    end
    check_eq("stall", stall_o, es);
    check_eq("flush", flush_o, ef);
    check_eq("jump_en", jump_en_o, ej);
    check_eq("jump_addr", jump_addr_o, ea);
    g_stall = stall_o; g_flush = flush_o; g_jen = jump_en_o; g_jaddr = jump_addr_o;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    m_pending = 0; m_fire = 0; m_tgt = '0; m_owed = 0; m_run = 0; m_to = 0;
    m_dst = 0; m_ist = 0; m_lu = 0; m_red = 0;

    // Reset state
    do_reset();
    do_reset();
    idle(1);
    check_eq("rst_stall", g_stall, 5'b0);
    check_eq("rst_cnt_lu", cnt_lu_o, 0);

    // Load-use, two bubbles
    do_reset();
    n = 0;
    step(0, 0, '0, 1, 1, 0, 0, 0, 0);
    if (g_flush == 5'b00100 && g_stall == 5'b00011) n++;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 0, 0, 0, 0, 0, 0);
      if (g_flush == 5'b00100 && g_stall == 5'b00011) n++;
    end
    check_eq("lu_bubbles", n, 2);
    check_eq("lu_count", cnt_lu_o, 2);

    // Data-bus wait, three cycles
    do_reset();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 0, 0, 0, 0, 1, 0);
      if (g_stall == 5'b01111 && g_flush == 5'b10000) n++;
    end
    step(0, 0, '0, 0, 0, 0, 0, 1, 1);
    check_eq("dwait_release", g_stall, 5'b0);
    idle(1);
    check_eq("dwait_cycles", n, 3);
    check_eq("dstall_count", cnt_dstall_o, 3);

    // Jump during an unfinished fetch parks until the fetch ends
    do_reset();
    n = 0;
    step(0, 1, 64'h8000_0100, 0, 0, 1, 0, 0, 0);
    if (!g_jen) n++;
    step(0, 0, '0, 0, 0, 1, 0, 0, 0);
    if (!g_jen) n++;
    step(0, 0, '0, 0, 0, 1, 1, 0, 0);
    if (!g_jen) n++;
    check_eq("pend_quiet", n, 3);
    idle(1);
    check_eq("pend_fire", g_jen, 1);
    check_eq("pend_addr", g_jaddr, 64'h8000_0100);

    // Jump and load-use together: jump wins, no bubble follows
    do_reset();
    step(0, 1, 64'h1234_5678, 1, 1, 0, 0, 0, 0);
    check_eq("jlu_jen", g_jen, 1);
    check_eq("jlu_flush", g_flush, 5'b00110);
    idle(1);
    check_eq("jlu_nobubble", g_flush, 5'b0);

    // Watchdog on a stuck fetch
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 0, 1, 0, 0, 0);
    check_eq("wd_early", g_jen, 0);
    step(0, 0, '0, 0, 0, 1, 0, 0, 0);
    check_eq("wd_jen", g_jen, 1);
    check_eq("wd_addr", g_jaddr, TRAP);
    idle(3);
    check_eq("wd_sticky", timeout_o, 1);
    do_reset();
    idle(1);
    check_eq("wd_cleared", timeout_o, 0);

    // Reset while a redirect is parked drops it
    do_reset();
    step(0, 1, 64'hdead_0000, 0, 0, 1, 0, 0, 0);
    step(0, 0, '0, 0, 0, 1, 0, 0, 0);
    step(1, 0, '0, 0, 0, 1, 0, 0, 0);
    idle(1);
    check_eq("rstpend_stall", g_stall, 5'b0);
    step(0, 0, '0, 0, 0, 1, 1, 0, 0);
    idle(1);
    check_eq("rstpend_nojump", g_jen, 0);

    // Randomised traffic against the model (counters saturate, watchdog fires)
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) == 0),
           {$urandom, $urandom},
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 9) < 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
